// File: rtl/ext_fogzip_bs_reader.sv
`default_nettype none
// ============================================================================
// Module   : ext_fogzip_bs_reader
// Purpose  : Fetches a FogZip occupancy bitstream from external memory
//            (64-bit header word at the base address, then little-endian
//            packed 64-bit data words) and streams it out one byte per
//            valid/ready handshake towards octree reconstruction.
// Ports    : i_SYSTEM_clk / i_SYSTEM_rst   clock, async active-low reset
//            i_enable                      level run request, low = abort
//            i_base_address                header address
//            EXT_MEM_*                     single-outstanding read port
//            o_byte / o_byte_valid / i_byte_ready / o_byte_last  byte stream
//            o_last_valid_bits / o_byte_count  header fields
//            o_done / o_error / o_status   completion and state
// Revision : 1.0  initial release
// ============================================================================
module ext_fogzip_bs_reader #(
   parameter logic [31:0] MAX_BYTES = 32'd1048576
) (
   input  logic        i_SYSTEM_clk,
   input  logic        i_SYSTEM_rst,
   input  logic        i_enable,
   input  logic [31:0] i_base_address,
   output logic [31:0] EXT_MEM_readAddress,
   output logic        EXT_MEM_initReadTxn,
   input  logic [63:0] EXT_MEM_readPayload,
   input  logic        EXT_MEM_readTxnDone,
   input  logic        EXT_MEM_error,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   input  logic        i_byte_ready,
   output logic        o_byte_last,
   output logic [2:0]  o_last_valid_bits,
   output logic [31:0] o_byte_count,
   output logic        o_done,
   output logic        o_error,
   output logic [3:0]  o_status
);

   localparam logic [3:0] S_IDLE      = 4'b0000;
   localparam logic [3:0] S_RD_HDR    = 4'b0001;
   localparam logic [3:0] S_WAIT_HDR  = 4'b0010;
   localparam logic [3:0] S_CHECK     = 4'b0011;
   localparam logic [3:0] S_RD_WORD   = 4'b0100;
   localparam logic [3:0] S_WAIT_WORD = 4'b0101;
   localparam logic [3:0] S_EMIT      = 4'b0110;
   localparam logic [3:0] S_DONE      = 4'b0111;
   localparam logic [3:0] S_ERROR     = 4'b1111;

   logic [3:0]  state;
   logic [2:0]  byte_sel;     // byte lane inside the current word, wraps 7->0
   logic [31:0] byte_idx;     // stream position 0..N-1
   logic [31:0] word_addr;    // address of the next data word to fetch
   logic [63:0] word_buf;     // captured data word being emitted
   logic        handshake;
   logic        at_last_byte;

   assign handshake    = o_byte_valid & i_byte_ready;
   assign at_last_byte = (byte_idx == (o_byte_count - 32'd1));
   assign o_byte_last  = o_byte_valid & at_last_byte;
   assign o_status     = state;

   // Byte output is forced to zero whenever it is not valid so the stream
   // never exposes stale word contents.
   always_comb begin
      o_byte = 8'h00;
      if (o_byte_valid) begin
         o_byte = word_buf[{byte_sel, 3'b000} +: 8];
      end
   end

   always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
      if (!i_SYSTEM_rst) begin
         state               <= S_IDLE;
         byte_sel            <= 3'd0;
         byte_idx            <= 32'd0;
         word_addr           <= 32'd0;
         word_buf            <= 64'd0;
         EXT_MEM_readAddress <= 32'd0;
         EXT_MEM_initReadTxn <= 1'b0;
         o_byte_valid        <= 1'b0;
         o_last_valid_bits   <= 3'd0;
         o_byte_count        <= 32'd0;
         o_done              <= 1'b0;
         o_error             <= 1'b0;
      end else if (!i_enable) begin
         // Abort wins over everything; a late completion is simply ignored
         // because IDLE never looks at the memory port.
         state               <= S_IDLE;
         byte_sel            <= 3'd0;
         byte_idx            <= 32'd0;
         EXT_MEM_initReadTxn <= 1'b0;
         o_byte_valid        <= 1'b0;
         o_done              <= 1'b0;
         o_error             <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_RD_HDR;
            end
            S_RD_HDR: begin
               EXT_MEM_readAddress <= i_base_address;
               EXT_MEM_initReadTxn <= 1'b1;
               word_addr           <= i_base_address + 32'd8;
               state               <= S_WAIT_HDR;
            end
            S_WAIT_HDR: begin
               // Memory error outranks a simultaneous completion.
               if (EXT_MEM_error) begin
                  EXT_MEM_initReadTxn <= 1'b0;
                  o_error             <= 1'b1;
                  state               <= S_ERROR;
               end else if (EXT_MEM_readTxnDone) begin
                  EXT_MEM_initReadTxn <= 1'b0;
                  o_byte_count        <= EXT_MEM_readPayload[31:0];
                  o_last_valid_bits   <= EXT_MEM_readPayload[34:32];
                  state               <= S_CHECK;
               end
            end
            S_CHECK: begin
               byte_sel <= 3'd0;
               byte_idx <= 32'd0;
               if (o_byte_count == 32'd0) begin
                  o_done <= 1'b1;
                  state  <= S_DONE;
               end else if (o_byte_count > MAX_BYTES) begin
                  o_error <= 1'b1;
                  state   <= S_ERROR;
               end else begin
                  state <= S_RD_WORD;
               end
            end
            S_RD_WORD: begin
               EXT_MEM_readAddress <= word_addr;
               EXT_MEM_initReadTxn <= 1'b1;
               word_addr           <= word_addr + 32'd8;
               state               <= S_WAIT_WORD;
            end
            S_WAIT_WORD: begin
               if (EXT_MEM_error) begin
                  EXT_MEM_initReadTxn <= 1'b0;
                  o_error             <= 1'b1;
                  state               <= S_ERROR;
               end else if (EXT_MEM_readTxnDone) begin
                  EXT_MEM_initReadTxn <= 1'b0;
                  word_buf            <= EXT_MEM_readPayload;
                  o_byte_valid        <= 1'b1;
                  state               <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (handshake) begin
                  if (at_last_byte) begin
                     // Final byte: no further words are fetched.
                     o_byte_valid <= 1'b0;
                     o_done       <= 1'b1;
                     state        <= S_DONE;
                  end else begin
                     byte_idx <= byte_idx + 32'd1;
                     byte_sel <= byte_sel + 3'd1;
                     if (byte_sel == 3'd7) begin
                        o_byte_valid <= 1'b0;
                        state        <= S_RD_WORD;
                     end
                  end
               end
            end
            S_DONE, S_ERROR: begin
               state <= state;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ext_fogzip_bs_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ext_fogzip_bs_reader
// Purpose  : Self-checking bench for ext_fogzip_bs_reader. A memory model
//            serves the header and packed words from a byte array with
//            random latency; a monitor compares every read request and every
//            byte handshake against the byte array and the stream rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_ext_fogzip_bs_reader;

   localparam logic [31:0] MAX_BYTES = 32'd1048576;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [31:0] base;
   logic [31:0] addr;
   logic        init;
   logic [63:0] mem_payload;
   logic        mem_done;
   logic        mem_err;
   logic [7:0]  obyte;
   logic        valid;
   logic        ready;
   logic        last;
   logic [2:0]  lvb;
   logic [31:0] bcount;
   logic        done;
   logic        err;
   logic [3:0]  status;

   ext_fogzip_bs_reader #(.MAX_BYTES(MAX_BYTES)) dut (
      .i_SYSTEM_clk        (clk),
      .i_SYSTEM_rst        (rst_n),
      .i_enable            (enable),
      .i_base_address      (base),
      .EXT_MEM_readAddress (addr),
      .EXT_MEM_initReadTxn (init),
      .EXT_MEM_readPayload (mem_payload),
      .EXT_MEM_readTxnDone (mem_done),
      .EXT_MEM_error       (mem_err),
      .o_byte              (obyte),
      .o_byte_valid        (valid),
      .i_byte_ready        (ready),
      .o_byte_last         (last),
      .o_last_valid_bits   (lvb),
      .o_byte_count        (bcount),
      .o_done              (done),
      .o_error             (err),
      .o_status            (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   logic [7:0]  mem_bytes [0:63];
   logic [31:0] cur_n;
   logic [2:0]  cur_bits;
   logic [31:0] cur_base;
   int err_read, exp_reads, hs_count, rd_count, resp_count;
   int cyc = 0, first_hs_cyc, last_hs_cyc, done_cyc, ready_mode, lat_fixed;
   int n_cmp = 0, n_bad = 0;
   logic [7:0] last_byte_seen;
   logic prev_init = 0, prev_stall = 0, prev_en = 0, prev_last = 0, prev_done = 0;
   logic [31:0] prev_addr = 0;
   logic [7:0]  prev_byte = 0;
   logic bnd_drop = 0, bnd_pending = 0;
   int bnd_cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mem_read(input logic [31:0] a);
      logic [63:0] w;
      int k, idx;
      if (a == cur_base) return {29'd0, cur_bits, cur_n};
      w = 64'd0;
      k = int'((a - cur_base - 32'd8) >> 3);
      for (int b = 0; b < 8; b++) begin
         idx = 8 * k + b;
         if (idx >= 0 && idx < 64) w[8*b +: 8] = mem_bytes[idx];
      end
      return w;
   endfunction

   // Memory: one response per request after 0..3 idle cycles (or fixed).
   initial begin : mem_model
      int lat;
      lat = -1;
      mem_done = 1'b0; mem_err = 1'b0; mem_payload = 64'd0;
      forever begin
         @(posedge clk); #1;
         mem_done = 1'b0; mem_err = 1'b0;
         if (!rst_n || !init) lat = -1;
         else begin
            if (lat < 0) lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            if (lat == 0) begin
               mem_done    = 1'b1;
               mem_payload = mem_read(addr);
               if (resp_count == err_read) mem_err = 1'b1;
               resp_count++;
               lat = -1;
            end else lat--;
         end
      end
   end

   // Consumer ready: 0 tied high, 1 toggle, 2 random, other held low.
   initial begin : ready_gen
      ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            2:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
         endcase
      end
   end

   // Compare process: read requests and byte stream against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (init && !prev_init) begin
            check("rd_addr", addr, cur_base + 32'(8 * rd_count));
            check("rd_budget", rd_count < exp_reads, 1);
            if (bnd_pending) begin
               check("word_req_gap", cyc, bnd_cyc + 2);
               bnd_pending = 1'b0;
            end
            rd_count++;
         end
         if (init && prev_init) check("rd_addr_stable", addr, prev_addr);
         if (prev_stall && prev_en) begin
            check("hold_valid", valid, 1);
            check("hold_byte", obyte, prev_byte);
            check("hold_last", last, prev_last);
         end
         if (bnd_drop) begin
            check("bnd_valid_drop", valid, 0);
            bnd_drop = 1'b0;
         end
         if (last && !valid) check("last_without_valid", last, 0);
         if (valid && hs_count >= int'(cur_n)) check("valid_past_end", hs_count, cur_n);
         if (valid && ready && enable && hs_count < int'(cur_n)) begin
            check("byte", obyte, (hs_count < 64) ? mem_bytes[hs_count] : 8'h00);
            check("byte_last", last, hs_count == int'(cur_n) - 1);
            check("byte_count_out", bcount, cur_n);
            check("last_bits_out", lvb, cur_bits);
            if (hs_count % 8 == 7 && hs_count != int'(cur_n) - 1) begin
               bnd_drop = 1'b1; bnd_pending = 1'b1; bnd_cyc = cyc;
            end
            if (hs_count == 0) first_hs_cyc = cyc;
            last_byte_seen = obyte;
            last_hs_cyc = cyc;
            hs_count++;
         end
         if (done && !prev_done) done_cyc = cyc;
      end
      prev_init  = init;
      prev_addr  = addr;
      prev_stall = valid && !ready;
      prev_en    = enable;
      prev_byte  = obyte;
      prev_last  = last;
      prev_done  = done;
   end

   task automatic arm(input int n, input int bits, input logic [31:0] b, input int rmode,
                      input int errr, input bit rnd);
      cur_n = 32'(n); cur_bits = 3'(bits); cur_base = b; base = b;
      err_read = errr; ready_mode = rmode;
      hs_count = 0; rd_count = 0; resp_count = 0;
      bnd_drop = 1'b0; bnd_pending = 1'b0;
      done_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
      if (errr >= 0) exp_reads = errr + 1;
      else exp_reads = (n == 0 || n > int'(MAX_BYTES)) ? 1 : 1 + (n + 7) / 8;
      if (rnd) for (int i = 0; i < 64; i++) mem_bytes[i] = 8'($urandom);
   endtask

   task automatic run(input int n, input int bits, input logic [31:0] b, input int rmode,
                      input int errr, input bit rnd, input bit exp_err);
      int exp_del, k;
      arm(n, bits, b, rmode, errr, rnd);
      if (errr >= 0) begin
         exp_del = 8 * (errr - 1);
         if (exp_del > n) exp_del = n;
         if (exp_del < 0) exp_del = 0;
      end else exp_del = (n > int'(MAX_BYTES)) ? 0 : n;
      @(posedge clk); #1;
      enable = 1'b1;
      // Header latency: request visible two cycles after enable is sampled.
      @(negedge clk); check("lat_c0_init", init, 0);
      @(negedge clk); check("lat_c1_status", status, 4'h1); check("lat_c1_init", init, 0);
      @(negedge clk); check("lat_c2_init", init, 1); check("lat_c2_status", status, 4'h2);
      k = 0;
      while (!(done || err) && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      check("run_timeout", k < 3000, 1);
      repeat (4) @(posedge clk);
      #1;
      check("delivered", hs_count, exp_del);
      check("reads", rd_count, exp_reads);
      check("final_status", status, exp_err ? 4'hF : 4'h7);
      check("done_flag", done, !exp_err);
      check("error_flag", err, exp_err);
      check("count_out", bcount, cur_n);
      check("bits_out", lvb, cur_bits);
      if (!exp_err && n > 0) check("done_latency", done_cyc, last_hs_cyc + 1);
      if (!exp_err && n > 0 && n <= 8 && rmode == 0)
         check("back_to_back", last_hs_cyc - first_hs_cyc, n - 1);
      enable = 1'b0;
      @(posedge clk); @(negedge clk);
      check("idle_done", done, 0);
      check("idle_error", err, 0);
      check("idle_status", status, 4'h0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int k;
      rst_n = 1'b0; enable = 1'b0; base = 32'd0;
      ready_mode = 3; lat_fixed = -1; err_read = -1; exp_reads = 0;
      cur_n = 0; cur_bits = 0; cur_base = 0;
      hs_count = 0; rd_count = 0; resp_count = 0;
      for (int i = 0; i < 64; i++) mem_bytes[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_status", status, 4'h0);
      check("rst_addr", addr, 0);
      check("rst_init", init, 0);
      check("rst_byte", obyte, 0);
      check("rst_valid", valid, 0);
      check("rst_count", bcount, 0);
      check("rst_bits", lvb, 0);
      check("rst_done_err", {done, err, last}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // N=5, word0 = 0x000000EEDDCCBBAA, ready tied high
      mem_bytes[0] = 8'hAA; mem_bytes[1] = 8'hBB; mem_bytes[2] = 8'hCC;
      mem_bytes[3] = 8'hDD; mem_bytes[4] = 8'hEE;
      run(5, 3, 32'h1000_0000, 0, -1, 1'b0, 1'b0);
      check("t1_last_byte", last_byte_seen, 8'hEE);

      // N=17 with ready toggling
      run(17, 5, 32'h2000_0040, 1, -1, 1'b1, 1'b0);
      // N=0
      run(0, 0, 32'h1000_0000, 0, -1, 1'b1, 1'b0);
      // memory error on the second word's completion
      run(20, 2, 32'h1000_0100, 0, 2, 1'b1, 1'b1);
      // oversize header
      run(int'(MAX_BYTES) + 1, 1, 32'h1000_0200, 0, -1, 1'b1, 1'b1);

      // abort mid-EMIT while byte 3 is presented
      arm(20, 4, 32'h3000_0000, 0, -1, 1'b1);
      @(posedge clk); #1;
      enable = 1'b1;
      k = 0;
      while (!(hs_count == 3 && valid) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      check("abort_reach", k < 500, 1);
      enable = 1'b0; ready_mode = 3;
      @(posedge clk); @(negedge clk);
      check("abort_valid", valid, 0);
      check("abort_status", status, 4'h0);
      check("abort_init", init, 0);
      // re-enable refetches the header from the base
      run(12, 6, 32'h3000_0000, 0, -1, 1'b1, 1'b0);

      // abort while the header read is outstanding
      arm(10, 1, 32'h4000_0000, 0, -1, 1'b1);
      lat_fixed = 20;
      @(posedge clk); #1;
      enable = 1'b1;
      k = 0;
      while (!(status == 4'h2 && init) && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("hdr_wait_reach", k < 50, 1);
      enable = 1'b0;
      @(posedge clk); @(negedge clk);
      check("abort_rd_init", init, 0);
      check("abort_rd_status", status, 4'h0);
      lat_fixed = -1;
      repeat (2) @(posedge clk);

      // asynchronous reset while waiting for a data word
      arm(20, 7, 32'h5000_0000, 0, -1, 1'b1);
      lat_fixed = 6;
      @(posedge clk); #1;
      enable = 1'b1;
      k = 0;
      while (status != 4'h5 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("wait_word_reach", k < 100, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_status", status, 4'h0);
      check("arst_addr", addr, 0);
      check("arst_init", init, 0);
      check("arst_count", bcount, 0);
      check("arst_bits", lvb, 0);
      check("arst_misc", {obyte, valid, last, done, err}, 0);
      enable = 1'b0; lat_fixed = -1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);

      // randomized streams
      for (int i = 0; i < 8; i++) begin
         run(int'($urandom_range(1, 40)), int'($urandom_range(0, 7)),
             $urandom & 32'hFFFF_FFF8, 2, -1, 1'b1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ext_fogzip_bs_reader.md
# ext_fogzip_bs_reader

Bitstream fetch and unpack stage on the FogZip decode side. It reads the compressed occupancy bitstream that the FogZip encoder extension leaves in external memory and streams it out one occupancy byte per handshake. The memory layout is a 64-bit header word at the base address, followed by packed bitstream words. The block feeds the octree reconstruction stage. It also gives the bench a way to read back encoder output.

## Interface
Parameters:
- MAX_BYTES, 32'd1048576: largest byte count accepted from the header; anything larger is an error.

Ports:
- i_SYSTEM_clk  in  1  system clock; single clock domain.
- i_SYSTEM_rst  in  1  reset; asynchronous, active-low.
- i_enable  in  1  level run request. Rising level in IDLE starts a fetch; low in any state aborts to IDLE.
- i_base_address  in  32  header address; bitstream word k is at base+8+8k.
- EXT_MEM_readAddress  out  32  read address.
- EXT_MEM_initReadTxn  out  1  read request, held high until EXT_MEM_readTxnDone.
- EXT_MEM_readPayload  in  64  read data, valid in the cycle EXT_MEM_readTxnDone=1.
- EXT_MEM_readTxnDone  in  1  read completion strobe.
- EXT_MEM_error  in  1  memory error strobe.
- o_byte  out  8  occupancy byte.
- o_byte_valid  out  1  o_byte valid.
- i_byte_ready  in  1  consumer accepts o_byte.
- o_byte_last  out  1  high with the final byte of the stream.
- o_last_valid_bits  out  3  header [34:32]; stable from CHECK until return to IDLE.
- o_byte_count  out  32  header [31:0]; stable from CHECK until return to IDLE.
- o_done  out  1  stream fully delivered; held while i_enable stays high.
- o_error  out  1  memory error or oversize header; held while i_enable stays high.
- o_status  out  4  current state encoding.

## Operation
- Header word: [31:0] = N, the total byte count. [63:32] = last-byte valid bits; only [34:32] are used.
- Bitstream packing: byte j sits in word j/8, at bits [8*(j%8)+7 : 8*(j%8)]. Words are packed little-endian.
- Number of words fetched = ceil(N/8). No reads are issued beyond that count.
- States and encodings:
  - IDLE 0000
  - RD_HDR 0001
  - WAIT_HDR 0010
  - CHECK 0011
  - RD_WORD 0100
  - WAIT_WORD 0101
  - EMIT 0110
  - DONE 0111
  - ERROR 1111
- Transitions:
  - IDLE → RD_HDR when i_enable=1.
  - RD_HDR → WAIT_HDR.
  - WAIT_HDR → CHECK on readTxnDone.
  - CHECK → DONE if N=0. CHECK → ERROR if N>MAX_BYTES. Otherwise CHECK → RD_WORD.
  - RD_WORD → WAIT_WORD.
  - WAIT_WORD → EMIT on readTxnDone.
  - EMIT → RD_WORD after a handshake on byte 7 of a word that is not the final word.
  - EMIT → DONE after a handshake on byte N-1.
- Error and abort:
  - EXT_MEM_error in WAIT_HDR or WAIT_WORD → ERROR, even if readTxnDone is asserted in the same cycle.
  - i_enable=0 in any state → IDLE on the next edge. This takes priority over every other transition.
- Counters:
  - A 3-bit byte selector that wraps 7→0.
  - A 32-bit byte index running 0..N-1.
  - A 32-bit word address that increments by 8 per word fetched.
- o_byte_last=1 exactly when byte index = N-1 and o_byte_valid=1.

## Timing
- Reset values (i_SYSTEM_rst=0): state IDLE. Every output is 0, including EXT_MEM_readAddress, o_byte, o_byte_count and o_last_valid_bits.
- Reads:
  - EXT_MEM_initReadTxn rises the cycle after entry to RD_HDR or RD_WORD.
  - It stays high until readTxnDone is sampled, and is 0 the following cycle.
  - EXT_MEM_readAddress is stable for the whole request.
- Payload is captured on the edge where readTxnDone=1.
- Header latency: i_enable is sampled high in IDLE at cycle 0. The header request is visible at cycle 2.
- Byte streaming:
  - o_byte_valid rises 1 cycle after the word capture.
  - Throughput is one byte per cycle while i_byte_ready=1.
  - o_byte and o_byte_last are held stable while valid=1 and ready=0.
- Word boundary: valid drops the cycle after the handshake on byte 7. The next word request is issued 1 cycle later.
- o_done and o_error go high 1 cycle after entering DONE or ERROR. They fall 1 cycle after i_enable falls.
- Abort mid-read: initReadTxn drops within 1 cycle of i_enable falling. A late readTxnDone is ignored in IDLE.

## Test plan
- Header N=5, bits=3, word0=0x0000_00EE_DDCC_BBAA, ready tied high:
  - Outputs AA,BB,CC,DD,EE on 5 consecutive cycles.
  - o_byte_last is set on EE, with o_last_valid_bits=3.
  - Exactly 2 reads are issued, at base and base+8.
  - o_done rises the cycle after EE.
- N=17, with ready toggling every other cycle:
  - 17 bytes are delivered in order.
  - 4 reads are issued, at base, +8, +16, +24.
  - Data stays stable while ready=0.
- N=0: one read only, then DONE, with o_byte_valid never asserted.
- EXT_MEM_error in the cycle of the second word's readTxnDone:
  - ERROR state, o_status=1111.
  - o_error is high.
  - No further bytes are emitted.
- Header N=MAX_BYTES+1: ERROR directly from CHECK, with no word reads.
- Abort and reset:
  - i_enable dropped mid-EMIT at byte 3: valid is 0 and the block is in IDLE the next cycle. Re-enabling refetches the header.
  - Asynchronous reset asserted mid-WAIT_WORD: all outputs are 0 immediately.
